// File: rtl/matvec_dmem_loader.sv
// Streams a matrix-vector problem (rows, cols, column-major matrix, vector) into CPU data memory
// and holds the CPU in reset until the whole image has been written.
module matvec_dmem_loader #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int MAT_BASE = 0,
    parameter int VEC_BASE = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [2:0] {
        IDLE, HDR_ROWS, HDR_COLS, CHECK, MATRIX, VECTOR, DONE, ERROR
    } state_t;

    localparam logic [2*ADDR_W-1:0] MAT_SPAN  = (2*ADDR_W)'(VEC_BASE - MAT_BASE);
    localparam logic [DATA_W-1:0]   VEC_SPAN  = DATA_W'((2**ADDR_W) - VEC_BASE);
    localparam logic [ADDR_W-1:0]   ROWS_ADDR = ADDR_W'(MAT_BASE);
    localparam logic [ADDR_W-1:0]   COLS_ADDR = ADDR_W'(MAT_BASE + 1);
    localparam logic [ADDR_W-1:0]   MAT_ADDR  = ADDR_W'(MAT_BASE + 2);
    localparam logic [ADDR_W-1:0]   VEC_ADDR  = ADDR_W'(VEC_BASE);

    state_t              state, state_next;
    logic [DATA_W-1:0]   rows_r, cols_r;
    logic [ADDR_W-1:0]   cnt, mat_last, vec_last;
    logic [2*ADDR_W-1:0] prod;
    logic                hdr_bad, accept, start_ok;

    // Header bits at or above ADDR_W are rejected separately, so the low bits give the exact product.
    assign prod     = {{ADDR_W{1'b0}}, rows_r[ADDR_W-1:0]} * {{ADDR_W{1'b0}}, cols_r[ADDR_W-1:0]};
    assign hdr_bad  = (rows_r == '0) || (cols_r == '0)
                   || (|rows_r[DATA_W-1:ADDR_W]) || (|cols_r[DATA_W-1:ADDR_W])
                   || ((prod + (2*ADDR_W)'(2)) > MAT_SPAN)
                   || (cols_r > VEC_SPAN);
    assign vec_last = cols_r[ADDR_W-1:0] - ADDR_W'(1);
    assign accept   = in_valid && in_ready;
    assign start_ok = start && (state == IDLE || state == DONE || state == ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE:     if (start) state_next = HDR_ROWS;
            HDR_ROWS: begin
                in_ready = 1'b1;
                if (in_valid) state_next = HDR_COLS;
            end
            HDR_COLS: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CHECK;
            end
            CHECK:    state_next = hdr_bad ? ERROR : MATRIX;
            MATRIX: begin
                in_ready = 1'b1;
                if (in_valid && cnt == mat_last) state_next = VECTOR;
            end
            VECTOR: begin
                in_ready = 1'b1;
                if (in_valid && cnt == vec_last) state_next = DONE;
            end
            DONE, ERROR: if (start) state_next = HDR_ROWS;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            rows_r        <= '0;
            cols_r        <= '0;
            cnt           <= '0;
            mat_last      <= '0;
            words_written <= '0;
            load_done     <= 1'b0;
            cpu_rst_n     <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_wdata <= in_data;
                case (state)
                    HDR_ROWS: begin mem_addr <= ROWS_ADDR; rows_r <= in_data; end
                    HDR_COLS: begin mem_addr <= COLS_ADDR; cols_r <= in_data; end
                    MATRIX:   mem_addr <= MAT_ADDR + cnt;
                    default:  mem_addr <= VEC_ADDR + cnt;
                endcase
            end
            // One counter walks the matrix, then restarts for the vector.
            if (state == CHECK) begin
                cnt      <= '0;
                mat_last <= prod[ADDR_W-1:0] - ADDR_W'(1);
            end else if (accept && (state == MATRIX || state == VECTOR)) begin
                cnt <= (state == MATRIX && cnt == mat_last) ? '0 : cnt + ADDR_W'(1);
            end
            if (start_ok)    words_written <= '0;
            else if (mem_we) words_written <= words_written + (ADDR_W+1)'(1);
            // Registered from DONE so release lands one cycle after the final write.
            load_done <= (state == DONE) && !start;
            cpu_rst_n <= (state == DONE) && !start;
            load_err  <= (state == ERROR) && !start;
        end
    end

endmodule

// File: tb/tb_matvec_dmem_loader.sv
// Directed bench for matvec_dmem_loader: expected writes are queued at stimulus time and
// popped by an independent write monitor.
module tb_matvec_dmem_loader;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_rst_n;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_written;

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_e;

    matvec_dmem_loader #(.DATA_W(DW), .ADDR_W(AW), .MAT_BASE(0), .VEC_BASE(512)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_err(load_err),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_we must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0d:%0h expected=none", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", 64'(mem_addr), 64'(mon_e[AW+DW-1:DW]));
                chk("write_data", 64'(mem_wdata), 64'(mon_e[DW-1:0]));
            end
        end
    end

    task automatic send(input logic [DW-1:0] w, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic int gap_of(input bit bp, input int idx);
        return (bp && (idx % 2 == 1)) ? 2 : 0;
    endfunction

    task automatic load(input logic [DW-1:0] rows, input logic [DW-1:0] cols, input int dbase,
                        input bit bp, input int start_k, input int abort_j);
        bit  bad;
        int  total;
        int  idx;
        bad = (rows == 0) || (cols == 0) || (rows >= 1024) || (cols >= 1024) || (cols > 512)
           || ((rows < 1024 && cols < 1024) && (rows * cols + 2 > 512));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        exp_q.push_back({AW'(0), rows});
        send(rows, gap_of(bp, idx++));
        exp_q.push_back({AW'(1), cols});
        send(cols, gap_of(bp, idx++));
        chk("check_cycle_ready", 64'(in_ready), 64'(0));
        if (bad) begin
            repeat (2) @(negedge clk);
            chk("err_flag", 64'(load_err), 64'(1));
            chk("err_cpu_rst_n", 64'(cpu_rst_n), 64'(0));
            chk("err_ready", 64'(in_ready), 64'(0));
            chk("err_words", 64'(words_written), 64'(2));
            chk("err_done", 64'(load_done), 64'(0));
            in_valid = 1'b1;
            in_data  = 32'hdead_beef;
            repeat (3) @(negedge clk);
            in_valid = 1'b0;
            return;
        end
        total = int'(rows) * int'(cols);
        for (int k = 0; k < total; k++) begin
            exp_q.push_back({AW'(2 + k), DW'(dbase + k)});
            send(DW'(dbase + k), gap_of(bp, idx++));
            if (k == start_k) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        for (int j = 0; j < int'(cols); j++) begin
            exp_q.push_back({AW'(512 + j), DW'(dbase + total + j)});
            send(DW'(dbase + total + j), gap_of(bp, idx++));
            if (j == abort_j) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_we", 64'(mem_we), 64'(0));
                chk("abort_addr", 64'(mem_addr), 64'(0));
                chk("abort_wdata", 64'(mem_wdata), 64'(0));
                chk("abort_ready", 64'(in_ready), 64'(0));
                chk("abort_cpu_rst_n", 64'(cpu_rst_n), 64'(0));
                chk("abort_done", 64'(load_done), 64'(0));
                chk("abort_err", 64'(load_err), 64'(0));
                chk("abort_words", 64'(words_written), 64'(0));
                exp_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        chk("done_not_early", 64'(load_done), 64'(0));
        chk("cpu_rst_not_early", 64'(cpu_rst_n), 64'(0));
        @(negedge clk);
        chk("done_flag", 64'(load_done), 64'(1));
        chk("done_cpu_rst_n", 64'(cpu_rst_n), 64'(1));
        chk("done_err", 64'(load_err), 64'(0));
        chk("done_words", 64'(words_written), 64'(total + int'(cols) + 2));
        chk("done_no_write", 64'(mem_we), 64'(0));
        repeat (3) @(negedge clk);
        chk("done_queue_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'(0));
        chk("rst_we", 64'(mem_we), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_cpu_rst_n", 64'(cpu_rst_n), 64'(0));
        chk("rst_done", 64'(load_done), 64'(0));
        chk("rst_err", 64'(load_err), 64'(0));
        chk("rst_words", 64'(words_written), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        load(2, 3, 1, 1'b0, -1, -1);              // nominal 2x3
        load(2, 3, 1, 1'b1, -1, -1);              // backpressure
        load(0, 4, 1, 1'b0, -1, -1);              // rows = 0 rejected
        load(1, 1, 5, 1'b0, -1, -1);              // recovery 1x1: 1,1,5,6
        load(32, 16, 1, 1'b0, -1, -1);            // 514 words: too big
        load(30, 17, 1, 1'b0, -1, -1);            // exactly 512 words, last matrix at 511
        load(32'hffff_ffff, 1, 1, 1'b0, -1, -1);  // negative rows rejected
        load(2, 3, 1, 1'b0, 2, -1);               // start pulse during MATRIX
        load(2, 3, 1, 1'b0, -1, 1);               // async reset mid-VECTOR
        load(2, 3, 1, 1'b0, -1, -1);              // full load after reset

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
